// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control decoder and the execute stage.
package alu_pkg;

  // 4-bit ALU control codes; 1010-1111 are unassigned and produce zero.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_ctl_t;

  // Execute-stage control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } exec_state_t;

  // Ceiling log2, used to size the shift-amount field and counter.
  function automatic int unsigned alu_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU operations (everything except shifts).
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      alu_ctl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  // Select the operation; shift and unassigned codes yield zero here.
  always_comb begin
    result = '0;
    case (alu_ctl)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: single-cycle ALU ops, bit-serial shifts, and a one-entry
// output holding register with valid/ready handshakes and flush.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_alu_ctl,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);

  localparam int unsigned SHW = alu_log2(XLEN);

  exec_state_t     state, state_nxt;
  logic [XLEN-1:0] core_result;
  logic [XLEN-1:0] single_result;
  logic [XLEN-1:0] shreg;
  logic [XLEN-1:0] shreg_step;
  logic [XLEN-1:0] result_q;
  logic [SHW-1:0]  shamt;
  logic [SHW-1:0]  cnt;
  logic [TAGW-1:0] tag_q;
  logic            zero_q;
  logic            shift_left;
  logic            shift_arith;
  logic            accept;
  logic            op_is_shift;
  logic            op_multi;
  logic            last_shift;

  alu_core #(.XLEN(XLEN)) u_core (
    .alu_ctl (in_alu_ctl),
    .a       (in_a),
    .b       (in_b),
    .result  (core_result)
  );

  assign shamt       = in_b[SHW-1:0];
  assign op_is_shift = (in_alu_ctl == ALU_SLL) || (in_alu_ctl == ALU_SRL) ||
                       (in_alu_ctl == ALU_SRA);
  assign op_multi    = op_is_shift && (shamt != '0);
  // A zero-amount shift passes operand A straight through.
  assign single_result = op_is_shift ? in_a : core_result;
  assign accept      = in_valid && in_ready;
  assign last_shift  = (cnt == SHW'(1));
  assign shreg_step  = shift_left ? {shreg[XLEN-2:0], 1'b0}
                                  : {shift_arith & shreg[XLEN-1], shreg[XLEN-1:1]};

  assign out_valid  = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);
  assign out_result = result_q;
  assign out_zero   = zero_q;
  assign out_tag    = tag_q;

  // Input acceptance: idle, or draining the held result this cycle; never on flush.
  always_comb begin
    in_ready = 1'b0;
    if (!flush) begin
      case (state)
        ST_IDLE: in_ready = 1'b1;
        ST_DONE: in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  // Next-state logic; flush overrides everything except reset.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept) state_nxt = op_multi ? ST_SHIFT : ST_DONE;
        ST_SHIFT: if (last_shift) state_nxt = ST_DONE;
        ST_DONE: begin
          if (out_ready) begin
            if (accept) state_nxt = op_multi ? ST_SHIFT : ST_DONE;
            else        state_nxt = ST_IDLE;
          end
        end
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Datapath: load on accept, step the shifter while shifting, capture result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      cnt         <= '0;
      shift_left  <= 1'b0;
      shift_arith <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      tag_q       <= '0;
    end else if (accept) begin
      tag_q <= in_tag;
      if (op_multi) begin
        shreg       <= in_a;
        cnt         <= shamt;
        shift_left  <= (in_alu_ctl == ALU_SLL);
        shift_arith <= (in_alu_ctl == ALU_SRA);
      end else begin
        result_q <= single_result;
        zero_q   <= (single_result == '0);
      end
    end else if ((state == ST_SHIFT) && !flush) begin
      shreg <= shreg_step;
      cnt   <= cnt - SHW'(1);
      if (last_shift) begin
        result_q <= shreg_step;
        zero_q   <= (shreg_step == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus a random
// handshake run scored against an arithmetic reference model.
module tb_alu_exec_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TAGW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_alu_ctl;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_zero;
  logic [TAGW-1:0] out_tag;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec_stage #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_alu_ctl (in_alu_ctl),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result straight from the operation definitions.
  function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] c,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    int unsigned sh;
    sh = b % XLEN;
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd6:    return (a < b) ? 1 : 0;
      4'd7:    return a << sh;
      4'd8:    return a >> sh;
      4'd9:    return $signed(a) >>> sh;
      default: return 0;
    endcase
  endfunction

  // Cycles from accept edge to first out_valid sample (1 = right after accept).
  function automatic int unsigned ref_latency(input logic [3:0] c, input logic [XLEN-1:0] b);
    int unsigned sh;
    sh = b % XLEN;
    if ((c >= 4'd7) && (c <= 4'd9) && (sh != 0)) return 1 + sh;
    return 1;
  endfunction

  function automatic logic [XLEN-1:0] pick_operand();
    logic [XLEN-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(XLEN-1){1'b0}}};
      3:       v = {1'b0, {(XLEN-1){1'b1}}};
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with out_ready high and check latency, busy span and result.
  task automatic run_op(input string name, input logic [3:0] c,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [TAGW-1:0] t);
    int unsigned lat;
    int unsigned cycles;
    int unsigned busy_cnt;
    int unsigned guard;
    logic [XLEN-1:0] exp;
    lat = ref_latency(c, b);
    exp = ref_alu(c, a, b);
    out_ready = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    check({name, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_alu_ctl = c; in_a = a; in_b = b; in_tag = t;
    tick();
    in_valid = 1'b0;
    cycles = 1;
    busy_cnt = 0;
    while (!out_valid && cycles < XLEN + 8) begin
      check({name, "_in_ready_shift"}, in_ready, 0);
      busy_cnt += busy;
      tick();
      cycles++;
    end
    check({name, "_latency"}, cycles, lat);
    check({name, "_result"}, out_result, exp);
    check({name, "_zero"}, out_zero, (exp == 0));
    check({name, "_tag"}, out_tag, t);
    busy_cnt += busy;
    check({name, "_busy_cycles"}, busy_cnt, lat);
    tick();
    check({name, "_idle_after"}, busy, 0);
  endtask

  logic [XLEN-1:0] exp_res_q[$];
  logic [TAGW-1:0] exp_tag_q[$];
  int unsigned     exp_first_q[$];

  initial begin
    int unsigned cyc;
    logic        first_seen;
    logic        ov_seen;
    logic        hs;
    logic        acc;
    logic [3:0]  c;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_alu_ctl = '0; in_a = '0; in_b = '0; in_tag = '0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_zero", out_zero, 1);
    check("rst_out_tag", out_tag, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 5'd3);

    // SUB then SLT back-to-back with out_ready held high.
    out_ready = 1'b1;
    in_valid = 1'b1; in_alu_ctl = 4'd1; in_a = 32'd5; in_b = 32'd5; in_tag = 5'd4;
    tick();
    check("b2b_sub_valid", out_valid, 1);
    check("b2b_sub_result", out_result, 0);
    check("b2b_sub_zero", out_zero, 1);
    check("b2b_in_ready_done", in_ready, 1);
    in_alu_ctl = 4'd5; in_a = 32'hFFFF_FFFF; in_b = 32'd1; in_tag = 5'd5;
    tick();
    in_valid = 1'b0;
    check("b2b_slt_valid", out_valid, 1);
    check("b2b_slt_result", out_result, 1);
    check("b2b_slt_zero", out_zero, 0);
    check("b2b_slt_tag", out_tag, 5);
    tick();

    run_op("sra", 4'd9, 32'h8000_0000, 32'd4, 5'd6);
    run_op("srl", 4'd8, 32'h8000_0000, 32'd4, 5'd7);
    run_op("sll0", 4'd7, 32'h1234_5678, 32'd0, 5'd8);

    // XOR held under back-pressure while another op is offered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_alu_ctl = 4'd4; in_a = 32'hF0F0; in_b = 32'h0FF0; in_tag = 5'd9;
    tick();
    in_alu_ctl = 4'd0; in_a = 32'd10; in_b = 32'd20; in_tag = 5'd10;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_result", out_result, 32'hFF00);
      check("bp_tag", out_tag, 9);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_next_result", out_result, 30);
    check("bp_next_tag", out_tag, 10);
    tick();

    // Flush in the middle of a long SLL.
    in_valid = 1'b1; in_alu_ctl = 4'd7; in_a = 32'd1; in_b = 32'd31; in_tag = 5'd11;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("flush_busy_before", busy, 1);
    flush = 1'b1; in_valid = 1'b1; in_alu_ctl = 4'd0;
    #1;
    check("flush_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle", busy, 0);
    check("flush_out_valid", out_valid, 0);
    ov_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      ov_seen = ov_seen | out_valid;
    end
    check("flush_never_valid", ov_seen, 0);
    run_op("add_after_flush", 4'd0, 32'd100, 32'hFFFF_FFFF, 5'd12);

    // Asynchronous reset between clock edges while shifting.
    in_valid = 1'b1; in_alu_ctl = 4'd9; in_a = 32'h8000_0000; in_b = 32'd20; in_tag = 5'd13;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_result", out_result, 0);
    check("arst_out_zero", out_zero, 1);
    check("arst_out_tag", out_tag, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 1);
    #2;
    rst = 1'b0;
    tick();
    check("arst_still_idle", busy, 0);
    run_op("code_f", 4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 5'd14);

    // Random traffic with random back-pressure, scored in order.
    cyc = 0;
    first_seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (out_valid) begin
        if (exp_res_q.size() == 0) begin
          check("rnd_spurious_valid", out_valid, 0);
        end else if (!first_seen) begin
          check("rnd_latency", cyc, exp_first_q[0]);
          first_seen = 1'b1;
        end
      end
      c = 4'($urandom_range(0, 15));
      a = pick_operand();
      b = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 3)) : pick_operand();
      in_valid = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 7);
      in_alu_ctl = c; in_a = a; in_b = b; in_tag = TAGW'($urandom);
      #1;
      hs  = out_valid && out_ready;
      acc = in_valid && in_ready;
      if (hs) begin
        if (exp_res_q.size() != 0) begin
          check("rnd_result", out_result, exp_res_q[0]);
          check("rnd_zero", out_zero, (exp_res_q[0] == 0));
          check("rnd_tag", out_tag, exp_tag_q[0]);
          void'(exp_res_q.pop_front());
          void'(exp_tag_q.pop_front());
          void'(exp_first_q.pop_front());
        end
        first_seen = 1'b0;
      end
      if (acc) begin
        exp_res_q.push_back(ref_alu(c, a, b));
        exp_tag_q.push_back(in_tag);
        exp_first_q.push_back(cyc + ref_latency(c, b));
      end
      @(posedge clk);
      cyc++;
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < XLEN + 4 && exp_res_q.size() != 0; i++) begin
      if (out_valid) begin
        check("drain_result", out_result, exp_res_q[0]);
        check("drain_tag", out_tag, exp_tag_q[0]);
        void'(exp_res_q.pop_front());
        void'(exp_tag_q.pop_front());
        void'(exp_first_q.pop_front());
      end
      tick();
    end
    check("drain_empty", exp_res_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Execute stage that consumes the 4-bit ALU control code produced by the ALU control decoder together with two operands, and delivers a registered result to the writeback/branch logic. Single-cycle ops complete in one cycle; shifts run iteratively (one bit per cycle) to save area. Valid/ready handshakes on both sides with a one-entry output holding register; a synchronous flush discards in-flight work on pipeline redirect.

## Interface
- XLEN, 32: operand/result width; power of two, >= 8
- TAGW, 5: width of the passthrough tag (destination register index)
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; asynchronous and active-high
- flush  in  1  synchronous abort; drops accepted/pending operation
- in_valid  in  1  operation offered
- in_ready  out  1  stage can accept this cycle
- in_alu_ctl  in  4  operation code (below)
- in_a  in  XLEN  operand A
- in_b  in  XLEN  operand B; shift amount = in_b[log2(XLEN)-1:0]
- in_tag  in  TAGW  carried unchanged to out_tag
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- out_result  out  XLEN  result
- out_zero  out  1  out_result == 0
- out_tag  out  TAGW  tag of held result
- busy  out  1  state != IDLE

## Operation
- Codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed, result 1/0), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA; 1010–1111 -> result 0, treated as single-cycle.
- Arithmetic modulo 2^XLEN; overflow ignored. SLT/SLTU zero-extend the 1-bit outcome to XLEN.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On accept: non-shift op, or shift with shamt==0 -> compute, load result/tag, go DONE. Shift with shamt!=0 -> load A into shift register, counter=shamt, latch direction/arith, go SHIFT.
- SHIFT: each cycle shift register moves one bit (SLL: left, zero fill; SRL: right, zero fill; SRA: right, sign fill), counter decrements; when counter reaches 1 the final shift completes and state goes DONE in the same edge. in_ready=0.
- DONE: out_valid=1, outputs stable until handshake. On out_valid&&out_ready: if in_valid in same cycle, accept new op (in_ready = out_ready in DONE) and transition as from IDLE; else go IDLE.
- out_zero derived from the held result register, not from live inputs.
- flush: highest priority after rst; next state IDLE, out_valid=0; input offered in the flush cycle is not accepted (in_ready forced 0 when flush=1).

## Timing
- Reset values: state IDLE, out_valid 0, out_result 0, out_zero 1, out_tag 0, busy 0, in_ready 1 (combinational from state).
- Latency accept -> out_valid: 1 cycle for non-shift and zero-amount shifts; 1+shamt cycles otherwise (max XLEN).
- Throughput: one single-cycle op per cycle when out_ready held high (DONE->DONE back-to-back).
- Back-pressure: out_ready=0 holds DONE indefinitely; all out_* unchanged.
- in_ready is combinational from state, out_ready and flush; no other combinational input->output paths.
- rst mid-SHIFT: immediate return to reset values, partial result lost.

## Structure
- Shared package alu_pkg: ALU control code constants (shared with the ALU control decoder), FSM state encoding, helper for log2(XLEN).
- Sub-module alu_core: purely combinational single-cycle ops (all codes except shifts) — reusable elsewhere. Shift register, counter and FSM live in alu_exec_stage.

## Test plan
- ADD A=0x7FFFFFFF B=1, tag 3, out_ready=1 -> one cycle later out_valid, result 0x80000000, zero 0, tag 3.
- SUB A=5 B=5 then SLT A=0xFFFFFFFF B=1 back-to-back -> results 0 (zero=1) and 1 on consecutive cycles, no bubbles.
- SRA A=0x80000000 B=4 -> busy 5 cycles, in_ready 0 during SHIFT, result 0xF8000000; SRL same operands -> 0x08000000; SLL B=0 -> 1-cycle, result = A.
- out_ready low 3 cycles after XOR 0xF0F0 ^ 0x0FF0 -> result 0xFF00 held stable, in_ready 0 until handshake.
- flush during SHIFT of SLL A=1 B=31 -> next cycle IDLE, out_valid never asserted, next ADD completes normally.
- Async rst asserted mid-SHIFT between clock edges -> outputs at reset values immediately; code 1111 afterwards -> result 0, zero 1.
